io_bus_v2: RTL and testbench
============================

// Module: io_bus_v2
// PURPOSE
// Parametrised memory-mapped IO bridge: successor to the fixed-width IO decoder on the CPU data bus.
// Serves the non-memory half of the address space.
// Provides NUM_IO bidirectional GPIO with a 2-flop input synchroniser and edge-capture interrupts,
// a UART control front-end with an RX_DEPTH byte FIFO, and a single start_request/request_done handshake.
// Sits between the core's load/store unit and the pin muxes plus the existing uart instance.
// PARAMETERS
// NUM_IO     5   number of bidirectional GPIO pins (1..32)
// ADDR_BITS  8   register offset width decoded from target_address
// RX_DEPTH   4   UART RX FIFO depth in bytes; power of two, >=2
// PORTS
// clk              in   1          system clock, all logic on rising edge
// rst_n            in   1          asynchronous active-low reset
// start_request    in   1          request valid; held high until request_done seen
// is_write         in   1          1 = write, 0 = read; stable while start_request high
// target_address   in   ADDR_BITS  register byte offset
// write_value      in   32         write data
// fetched_value    out  32         read data; valid while request_done high
// request_done     out  1          completion; held high until start_request drops
// io_inputs        in   NUM_IO     raw pad inputs (asynchronous)
// io_outputs       out  NUM_IO     pad output values (OUT & DIR)
// io_direction     out  NUM_IO     1 = pin driven
// irq              out  1          OR of IRQ_STAT
// uart_start_tx    out  1          held high until uart_tx_done
// uart_tx_byte     out  8          TX data to uart
// uart_tx_done     in   1          uart finished current byte
// uart_rx_available in  1          uart holds a received byte
// uart_rx_byte     in   8          received byte
// uart_rx_clear    out  1          one-cycle pulse: byte taken from uart
// BEHAVIOUR
// Reset: all registers, FIFO pointers, count, flags, fetched_value, request_done, uart_* outputs and irq are 0.
// Register map (offset, access):
//   0x00 DIR RW
//   0x04 OUT RW
//   0x08 IN RO (synced & ~DIR)
//   0x0C RISE_EN RW
//   0x10 FALL_EN RW
//   0x14 IRQ_STAT R/W1C
//   0x18 UART_CTRL W: bit0 start TX, ignored while busy
//   0x1C UART_TX RW [7:0]
//   0x20 UART_RX R, pops FIFO
//   0x24 UART_STAT R: {rx_count, overflow[2], rx_nonempty[1], tx_busy[0]}; W: bit2=1 clears overflow
// Unmapped offsets: writes ignored, reads return 0. Unused upper bits read 0.
// Handshake FSM IDLE->DONE:
//   - In IDLE with start_request=1: perform the side effect once, register fetched_value, set request_done; next cycle go to DONE.
//     Latency from start_request to request_done is exactly 1 cycle.
//   - DONE holds request_done while start_request=1.
//   - start_request=0 -> IDLE, request_done=0 the same edge.
//   - A held request never repeats its side effect (no double FIFO pop).
// GPIO:
//   - io_outputs = OUT & DIR, combinational.
//   - Edge detect compares sync stage 2 against a delayed copy.
//   - Enabled edge sets its IRQ_STAT bit.
//   - When a set and a W1C hit the same bit in the same cycle, set wins.
// UART TX: CTRL bit0 while idle -> uart_start_tx=1; uart_tx_done -> uart_start_tx=0 the next edge.
// UART RX:
//   - uart_rx_available=1 and no clear in flight -> push uart_rx_byte and pulse uart_rx_clear.
//   - A full FIFO drops the byte, still pulses the clear, and sets the sticky overflow flag.
//   - Push and pop in the same cycle: both occur and the count is unchanged.
//   - Pop when empty returns 0 and the FIFO is unchanged.
//   - Pointers wrap modulo RX_DEPTH; count is $clog2(RX_DEPTH)+1 bits.
// An asynchronous reset mid-request or mid-TX aborts: FSM returns to IDLE and the FIFO is emptied.
// STRUCTURE
// Shared package: register offset localparams, UART_STAT bit indices, FSM state encodings.
// Sub-module sync_fifo (WIDTH=8, DEPTH=RX_DEPTH): push/pop/full/empty/count, async active-low reset.
// GPIO sync/edge logic, register file and FSM stay in io_bus_v2.
// TESTING
// 1. Reset, then read every mapped offset -> all return 0; irq=0; uart_start_tx=0.
// 2. Write DIR=0x03, OUT=0x1F -> io_outputs=0x03. Drive io_inputs=0x1C -> IN reads 0x1C 3 cycles later.
// 3. RISE_EN=0x04, raise io_inputs[2] -> IRQ_STAT=0x04 and irq=1. W1C 0x04 coinciding with a new edge -> bit stays 1.
// 4. Push 0xA5, 0x5A from uart -> UART_STAT rx_count=2; RX reads A5 then 5A then 0. A held start_request pops only once.
// 5. RX_DEPTH=4: push 5 bytes -> count=4 and overflow=1; the 5th byte is dropped; write UART_STAT bit2 -> overflow=0.
// 6. Write TX=0x41, CTRL=1 -> uart_start_tx=1. A second CTRL write while busy is ignored. uart_tx_done -> tx_busy=0.

Source files
------------

// File: rtl/io_bus_v2_pkg.sv
// Shared definitions for the io_bus_v2 IO bridge: register offsets, UART_STAT
// bit positions and handshake FSM states.
package io_bus_v2_pkg;

    localparam logic [7:0] REG_DIR       = 8'h00;
    localparam logic [7:0] REG_OUT       = 8'h04;
    localparam logic [7:0] REG_IN        = 8'h08;
    localparam logic [7:0] REG_RISE_EN   = 8'h0C;
    localparam logic [7:0] REG_FALL_EN   = 8'h10;
    localparam logic [7:0] REG_IRQ_STAT  = 8'h14;
    localparam logic [7:0] REG_UART_CTRL = 8'h18;
    localparam logic [7:0] REG_UART_TX   = 8'h1C;
    localparam logic [7:0] REG_UART_RX   = 8'h20;
    localparam logic [7:0] REG_UART_STAT = 8'h24;

    localparam int STAT_TX_BUSY    = 0;
    localparam int STAT_RX_NONEMPTY = 1;
    localparam int STAT_OVERFLOW   = 2;
    localparam int STAT_COUNT_LSB  = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DONE = 1'b1
    } bus_state_e;

endpackage

// File: rtl/io_bus_v2_sync_fifo.sv
// Small synchronous FIFO. A push into a full FIFO is accepted only when a pop
// frees a slot in the same cycle; a pop from an empty FIFO is ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/io_bus_v2.sv
// Memory-mapped IO bridge: GPIO with synchronised inputs and edge interrupts,
// UART TX/RX front-end, single-outstanding request/done handshake.
module io_bus_v2
    import io_bus_v2_pkg::*;
#(
    parameter int NUM_IO    = 5,
    parameter int ADDR_BITS = 8,
    parameter int RX_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_request,
    input  logic                  is_write,
    input  logic [ADDR_BITS-1:0]  target_address,
    input  logic [31:0]           write_value,
    output logic [31:0]           fetched_value,
    output logic                  request_done,
    input  logic [NUM_IO-1:0]     io_inputs,
    output logic [NUM_IO-1:0]     io_outputs,
    output logic [NUM_IO-1:0]     io_direction,
    output logic                  irq,
    output logic                  uart_start_tx,
    output logic [7:0]            uart_tx_byte,
    input  logic                  uart_tx_done,
    input  logic                  uart_rx_available,
    input  logic [7:0]            uart_rx_byte,
    output logic                  uart_rx_clear
);
    localparam int CW = $clog2(RX_DEPTH) + 1;

    bus_state_e        state_q, state_d;
    logic [NUM_IO-1:0] dir_q, out_q, rise_en_q, fall_en_q, irq_stat_q;
    logic [NUM_IO-1:0] sync1_q, sync2_q, prev_q, edge_set, w1c;
    logic [7:0]        tx_byte_q, rx_data;
    logic              tx_busy_q, overflow_q, clear_q;
    logic              access, wr, rd, rx_take, rx_pop, rx_full, rx_empty, overflow_set;
    logic [CW-1:0]     rx_count;
    logic [31:0]       rdata;
    logic              unused_bits;

    function automatic logic hit(input logic [ADDR_BITS-1:0] a, input logic [7:0] off);
        return a == ADDR_BITS'(off);
    endfunction

    // Side effects happen only on the IDLE->DONE edge, so a held request acts once.
    assign access = (state_q == ST_IDLE) && start_request;
    assign wr     = access && is_write;
    assign rd     = access && !is_write;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_request)  state_d = ST_DONE;
            ST_DONE: if (!start_request) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    assign request_done  = (state_q == ST_DONE);
    assign io_outputs    = out_q & dir_q;
    assign io_direction  = dir_q;
    assign irq           = |irq_stat_q;
    assign uart_start_tx = tx_busy_q;
    assign uart_tx_byte  = tx_byte_q;
    assign uart_rx_clear = clear_q;
    assign unused_bits   = &{1'b0, write_value};

    assign edge_set = (sync2_q & ~prev_q & rise_en_q) | (~sync2_q & prev_q & fall_en_q);
    assign w1c      = (wr && hit(target_address, REG_IRQ_STAT)) ? write_value[NUM_IO-1:0] : '0;

    // A byte is taken only when no clear is outstanding, so the uart sees one clear per byte.
    assign rx_take      = uart_rx_available && !clear_q;
    assign rx_pop       = rd && hit(target_address, REG_UART_RX) && !rx_empty;
    assign overflow_set = rx_take && rx_full && !rx_pop;

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rx_take),
        .pop       (rx_pop),
        .push_data (uart_rx_byte),
        .pop_data  (rx_data),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    always_comb begin
        rdata = '0;
        if      (hit(target_address, REG_DIR))      rdata[NUM_IO-1:0] = dir_q;
        else if (hit(target_address, REG_OUT))      rdata[NUM_IO-1:0] = out_q;
        else if (hit(target_address, REG_IN))       rdata[NUM_IO-1:0] = sync2_q & ~dir_q;
        else if (hit(target_address, REG_RISE_EN))  rdata[NUM_IO-1:0] = rise_en_q;
        else if (hit(target_address, REG_FALL_EN))  rdata[NUM_IO-1:0] = fall_en_q;
        else if (hit(target_address, REG_IRQ_STAT)) rdata[NUM_IO-1:0] = irq_stat_q;
        else if (hit(target_address, REG_UART_TX))  rdata[7:0]        = tx_byte_q;
        else if (hit(target_address, REG_UART_RX))  rdata[7:0]        = rx_data;
        else if (hit(target_address, REG_UART_STAT)) begin
            rdata[STAT_TX_BUSY]                   = tx_busy_q;
            rdata[STAT_RX_NONEMPTY]               = !rx_empty;
            rdata[STAT_OVERFLOW]                  = overflow_q;
            rdata[STAT_COUNT_LSB +: CW]           = rx_count;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q         <= '0;
            out_q         <= '0;
            rise_en_q     <= '0;
            fall_en_q     <= '0;
            irq_stat_q    <= '0;
            sync1_q       <= '0;
            sync2_q       <= '0;
            prev_q        <= '0;
            tx_byte_q     <= '0;
            tx_busy_q     <= 1'b0;
            overflow_q    <= 1'b0;
            clear_q       <= 1'b0;
            fetched_value <= '0;
        end else begin
            sync1_q <= io_inputs;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            clear_q <= rx_take;
            // New edges win over a simultaneous write-one-to-clear.
            irq_stat_q <= (irq_stat_q & ~w1c) | edge_set;
            if (wr && hit(target_address, REG_DIR))     dir_q     <= write_value[NUM_IO-1:0];
            if (wr && hit(target_address, REG_OUT))     out_q     <= write_value[NUM_IO-1:0];
            if (wr && hit(target_address, REG_RISE_EN)) rise_en_q <= write_value[NUM_IO-1:0];
            if (wr && hit(target_address, REG_FALL_EN)) fall_en_q <= write_value[NUM_IO-1:0];
            if (wr && hit(target_address, REG_UART_TX)) tx_byte_q <= write_value[7:0];
            if (wr && hit(target_address, REG_UART_CTRL) && write_value[0] && !tx_busy_q)
                tx_busy_q <= 1'b1;
            else if (uart_tx_done)
                tx_busy_q <= 1'b0;
            overflow_q <= overflow_set ||
                          (overflow_q && !(wr && hit(target_address, REG_UART_STAT) && write_value[2]));
            if (access) fetched_value <= is_write ? '0 : rdata;
        end
    end

endmodule

// File: tb/tb_io_bus_v2.sv
// Self-checking bench for io_bus_v2: read results are predicted into a queue at
// issue time and compared when request_done is observed.
module tb_io_bus_v2;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_request = 1'b0, is_write = 1'b0;
    logic [7:0]  target_address = '0;
    logic [31:0] write_value = '0, fetched_value;
    logic        request_done, irq, uart_start_tx, uart_rx_clear;
    logic [4:0]  io_inputs = '0, io_outputs, io_direction;
    logic [7:0]  uart_tx_byte, uart_rx_byte = '0;
    logic        uart_tx_done = 1'b0, uart_rx_available = 1'b0;

    int checks = 0, errors = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    io_bus_v2 #(.NUM_IO(5), .ADDR_BITS(8), .RX_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start_request(start_request), .is_write(is_write),
        .target_address(target_address), .write_value(write_value),
        .fetched_value(fetched_value), .request_done(request_done),
        .io_inputs(io_inputs), .io_outputs(io_outputs), .io_direction(io_direction),
        .irq(irq), .uart_start_tx(uart_start_tx), .uart_tx_byte(uart_tx_byte),
        .uart_tx_done(uart_tx_done), .uart_rx_available(uart_rx_available),
        .uart_rx_byte(uart_rx_byte), .uart_rx_clear(uart_rx_clear)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // One bus transaction; reads predict their result into the scoreboard.
    task automatic bus(input logic w, input logic [7:0] a, input logic [31:0] d,
                       input logic [31:0] exp, input string tag, input int hold = 0);
        int lat = 0;
        @(negedge clk);
        start_request = 1'b1; is_write = w; target_address = a; write_value = d;
        if (!w) begin exp_q.push_back(exp); tag_q.push_back(tag); end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1; lat++;
            if (request_done) break;
        end
        chk({tag, "_lat"}, lat, 1);
        if (!w) chk(tag_q.pop_front(), fetched_value, exp_q.pop_front());
        repeat (hold) @(posedge clk);
        @(negedge clk);
        start_request = 1'b0;
        @(posedge clk); #1;
        if (hold > 0) chk({tag, "_drop"}, {31'b0, request_done}, 0);
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string tag, input int hold = 0);
        bus(1'b0, a, '0, exp, tag, hold);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        bus(1'b1, a, d, '0, "wr");
    endtask

    task automatic uart_push(input logic [7:0] b);
        logic seen = 1'b0;
        @(negedge clk);
        uart_rx_available = 1'b1; uart_rx_byte = b;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(posedge clk); #1;
            seen = uart_rx_clear;
        end
        chk("rx_clear", {31'b0, seen}, 1);
        @(negedge clk);
        uart_rx_available = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_done", {31'b0, request_done}, 0);
        chk("rst_fetch", fetched_value, 0);
        @(negedge clk) rst_n = 1'b1;

        // Reset state of every mapped offset plus one unmapped offset
        for (int i = 0; i <= 10; i++) rd(8'(i * 4), 0, $sformatf("rst_rd%0d", i));
        chk("rst_irq", {31'b0, irq}, 0);
        chk("rst_tx", {31'b0, uart_start_tx}, 0);
        chk("rst_out", {27'b0, io_outputs}, 0);

        // GPIO output and input path
        wr(8'h00, 32'h03);
        wr(8'h04, 32'h1F);
        wr(8'h28, 32'hFF);
        chk("io_out", {27'b0, io_outputs}, 32'h03);
        chk("io_dir", {27'b0, io_direction}, 32'h03);
        rd(8'h00, 32'h03, "dir_rd");
        rd(8'h04, 32'h1F, "out_rd");
        rd(8'h28, 32'h00, "unmapped");
        @(negedge clk) io_inputs = 5'h1C;
        repeat (3) @(posedge clk);
        rd(8'h08, 32'h1C, "in_rd");

        // Rising-edge interrupt and set-beats-clear
        @(negedge clk) io_inputs = 5'h18;
        repeat (4) @(posedge clk);
        wr(8'h0C, 32'h04);
        @(negedge clk) io_inputs = 5'h1C;
        repeat (4) @(posedge clk);
        #1 chk("irq_set", {31'b0, irq}, 1);
        rd(8'h14, 32'h04, "irq_stat");
        @(negedge clk) io_inputs = 5'h18;
        repeat (4) @(posedge clk);
        @(negedge clk) io_inputs = 5'h1C;
        repeat (2) @(posedge clk);
        wr(8'h14, 32'h04);
        rd(8'h14, 32'h04, "irq_set_wins");
        wr(8'h14, 32'h04);
        rd(8'h14, 32'h00, "irq_w1c");
        chk("irq_clr", {31'b0, irq}, 0);

        // RX FIFO basic, held request pops only once
        uart_push(8'hA5);
        uart_push(8'h5A);
        rd(8'h24, (2 << 3) | 2, "stat2");
        rd(8'h20, 32'hA5, "rx0", 3);
        rd(8'h20, 32'h5A, "rx1");
        rd(8'h20, 32'h00, "rx_empty");
        rd(8'h24, 32'h00, "stat0");

        // Overflow: fifth byte dropped
        for (int i = 1; i <= 5; i++) uart_push(8'(i));
        rd(8'h24, (4 << 3) | 4 | 2, "stat_ovf");
        wr(8'h24, 32'h04);
        rd(8'h24, (4 << 3) | 2, "ovf_clr");
        for (int i = 1; i <= 4; i++) rd(8'h20, 32'(i), $sformatf("rxo%0d", i));
        rd(8'h20, 32'h00, "rxo_empty");

        // UART TX
        wr(8'h1C, 32'h41);
        rd(8'h1C, 32'h41, "tx_rd");
        wr(8'h18, 32'h01);
        chk("tx_start", {31'b0, uart_start_tx}, 1);
        chk("tx_byte", {24'b0, uart_tx_byte}, 32'h41);
        wr(8'h18, 32'h01);
        rd(8'h24, 32'h01, "tx_busy");
        @(negedge clk) uart_tx_done = 1'b1;
        @(negedge clk) uart_tx_done = 1'b0;
        chk("tx_done", {31'b0, uart_start_tx}, 0);
        rd(8'h24, 32'h00, "tx_idle");

        // Asynchronous reset mid-TX with data buffered
        uart_push(8'h77);
        wr(8'h18, 32'h01);
        @(negedge clk) rst_n = 1'b0;
        #1 chk("arst_tx", {31'b0, uart_start_tx}, 0);
        @(negedge clk) rst_n = 1'b1;
        rd(8'h24, 32'h00, "arst_stat");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
